// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame receiver.
package serial_frame_pkg;

  // Default payload width in bits.
  localparam int DATA_W_DEFAULT = 8;

  // Receiver FSM states, in the order they occur within a frame.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

endpackage

// File: rtl/frame_shift_reg.sv
// Payload shift register with bit counter. Each shift stores din at the bit
// position given by the counter, so the first bit received lands in bit 0.
module frame_shift_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shift_en,
  input  logic              clr,
  input  logic              din,
  output logic [DATA_W-1:0] q,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_q;
  logic [DATA_W-1:0] w_q_next;

  // Only the bit addressed by the counter takes din; all others hold.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_bit
      assign w_q_next[gi] = (r_count == CNT_W'(gi)) ? din : r_q[gi];
    end
  endgenerate

  // Clear on frame start, otherwise store one bit per shift enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_q     <= '0;
    end else if (clr) begin
      r_count <= '0;
      r_q     <= '0;
    end else if (shift_en) begin
      r_q     <= w_q_next;
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign q = r_q;
  // High while the next shift stores the final payload bit; kept independent
  // of shift_en so the FSM can combine them without a combinational loop.
  assign done = (r_count == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, optional even
// parity bit, stop bit. Completed frames are held in a single output register
// with valid/ready handshake; a frame that finds the register occupied is
// dropped and reported with a one-cycle overrun pulse.
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEFAULT,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sd,
  input  logic              bit_en,
  output logic [DATA_W-1:0] data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);

  rx_state_t r_state;
  rx_state_t w_state_next;

  logic              w_shift_en;
  logic              w_clr;
  logic              w_last_bit;
  logic              w_frame_done;
  logic [DATA_W-1:0] w_shift_q;

  logic              r_par_err;
  logic [DATA_W-1:0] r_data;
  logic              r_out_valid;
  logic              r_parity_err;
  logic              r_frame_err;
  logic              r_overrun;

  frame_shift_reg #(
    .DATA_W (DATA_W)
  ) u_shift (
    .clk      (clk),
    .reset    (reset),
    .shift_en (w_shift_en),
    .clr      (w_clr),
    .din      (sd),
    .q        (w_shift_q),
    .done     (w_last_bit)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and datapath controls; nothing advances without bit_en.
  always_comb begin
    w_state_next = r_state;
    w_shift_en   = 1'b0;
    w_clr        = 1'b0;
    w_frame_done = 1'b0;
    if (bit_en) begin
      case (r_state)
        IDLE: begin
          if (!sd) begin
            w_clr        = 1'b1;
            w_state_next = DATA;
          end
        end
        DATA: begin
          w_shift_en = 1'b1;
          if (w_last_bit) begin
            w_state_next = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          w_state_next = STOP;
        end
        STOP: begin
          w_frame_done = 1'b1;
          w_state_next = IDLE;
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  // Even parity check: data bits plus parity bit must XOR to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_par_err <= 1'b0;
    end else if (bit_en && (r_state == PARITY)) begin
      r_par_err <= (^w_shift_q) ^ sd;
    end
  end

  // Output register: load on completion if empty or being accepted this
  // edge, otherwise drop the new frame and flag overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data       <= '0;
      r_out_valid  <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_frame_done) begin
        if (!r_out_valid || out_ready) begin
          r_data       <= w_shift_q;
          r_parity_err <= (PARITY_EN != 0) ? r_par_err : 1'b0;
          r_frame_err  <= ~sd;
          r_out_valid  <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign data       = r_data;
  assign out_valid  = r_out_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;

endmodule
